execute_stage_pipe: RTL and testbench
=====================================

Name: execute_stage_pipe

Overview:
Parametrised, registered execute stage for the pipelined core. It forwards operands from EX/MEM and WB and selects the register or immediate operand. It performs single-cycle ALU ops and iterative unsigned MULT/DIV into HI/LO, and drives the EX/MEM pipeline register. It sits between the ID/EX register and the memory stage, and raises `stall` to freeze upstream while MULT/DIV is iterating.

Parameters:
XLEN, 32, datapath width (>=8)
REGW, 5, register-index width
SHW, 5, shift-amount width (shamt = imm[6+SHW-1:6])

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  synchronous active-low reset
in_valid  in  1  ID/EX holds a valid instruction
rs_val  in  XLEN  register operand A
rt_val  in  XLEN  register operand B
imm  in  XLEN  sign/zero-extended immediate
alu_src  in  1  0: B=fwd rt, 1: B=imm
alu_ctrl  in  4  decoded operation (encoding below)
reg_dst  in  1  0: dest=rt_idx, 1: dest=rd_idx
rd_idx  in  REGW  rd field
rt_idx  in  REGW  rt field
reg_write  in  1  instruction writes GPR
fwd_a_sel  in  2  00 rs_val, 01 out_result, 10 wb_data, 11 = 00
fwd_b_sel  in  2  same encoding, applied to rt_val
wb_data  in  XLEN  WB-stage write data
stall  out  1  MULT/DIV busy; upstream must hold inputs
out_valid  out  1  EX/MEM entry valid
out_result  out  XLEN  registered ALU result
out_zero  out  1  registered (ALU result == 0)
out_store_data  out  XLEN  registered forwarded B (pre alu_src mux)
out_dest  out  REGW  registered destination index
out_reg_write  out  1  registered reg_write & out_valid
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- alu_ctrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR, 1000 SLL, 1001 SRL, 1010 SRA (shift B by shamt), 0011 MFHI, 0100 MFLO, 1101 MULT, 1110 DIV; any other code gives result 0.
- ADD/SUB wrap modulo 2^XLEN, no overflow flag.
- Accept = in_valid & !stall. Non-MULT/DIV accept: every out_* register loads on the next edge (latency 1) and out_valid=1.
- No accept: out_valid=0 and out_reg_write=0 next edge; other out_* hold their values.
- MULT/DIV accept: out_valid=0 next edge (bubble). Operands latch (A=fwd A, B=fwd B, alu_src ignored), count=XLEN, busy=1.
- stall is combinational from busy. It is high for exactly XLEN cycles, starting the cycle after accept.
- MULT: shift-add, one bit per cycle; {hi,lo} = A*B unsigned (2*XLEN bits).
- DIV: restoring, one bit per cycle; lo = A/B, hi = A%B unsigned. B==0 gives lo = all ones, hi = A.
- hi/lo update on the final busy edge only; they hold during iteration. busy clears on that same edge.
- MFHI/MFLO accepted the cycle stall drops see the new values.
- Inputs presented while stall=1 are ignored.
- Forwarding applies before alu_src and the store-data path. fwd 01 uses the current out_result register.
- Reset (RST_N=0 at edge): all outputs, hi, lo, busy and count go to 0, and stall=0 the cycle after. Reset mid-MULT/DIV aborts it with no HI/LO write. Reset has priority over accept.

Test Plan:
- ADD rs=5, rt=7, alu_src=0, reg_dst=1, rd=3 -> next cycle out_result=12, out_zero=0, out_dest=3, out_valid=1, out_reg_write=1.
- SUB rs=9, imm=9, alu_src=1; then SLT rs=-1, rt=1 -> out_zero=1 with result 0; then out_result=1.
- Forwarding: out_result=20, wb_data=30, fwd_a_sel=01, fwd_b_sel=10, ADD -> out_result=50, out_store_data=30.
- MULT 0xFFFFFFFF*2 -> stall high exactly 32 cycles, one bubble, then hi=1, lo=0xFFFFFFFE; MFLO the cycle stall drops -> out_result=0xFFFFFFFE.
- DIV 17/5 -> hi=2, lo=3; DIV 17/0 -> lo=0xFFFFFFFF, hi=17; inputs changed mid-stall have no effect.
- Assert RST_N=0 on cycle 10 of a MULT -> all outputs 0 next cycle, stall=0, hi/lo=0; a following ADD proceeds normally.

Source files
------------

// File: rtl/execute_stage_pipe.sv
// Execute stage: operand forwarding, ALU, iterative unsigned MULT/DIV into HI/LO, EX/MEM register.
// Latency: 1 cycle for ALU ops into out_*; MULT/DIV take XLEN stalled cycles, HI/LO written on the last.
// Backpressure: stall (combinational from busy) freezes upstream; inputs presented while stalled are ignored.
//
// Ports:
//   CLK, RST_N        : clock (rising edge), synchronous active-low reset
//   in_valid, rs_val, rt_val, imm, alu_src, alu_ctrl, reg_dst, rd_idx, rt_idx, reg_write : ID/EX contents
//   fwd_a_sel, fwd_b_sel, wb_data : forwarding selects (00 reg, 01 out_result, 10 wb_data, 11 reg) and WB data
//   stall             : MULT/DIV busy, upstream must hold
//   out_valid, out_result, out_zero, out_store_data, out_dest, out_reg_write : EX/MEM register
//   hi, lo            : multiply/divide result registers
module execute_stage_pipe #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int SHW  = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            in_valid,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [XLEN-1:0] imm,
    input  logic            alu_src,
    input  logic [3:0]      alu_ctrl,
    input  logic            reg_dst,
    input  logic [REGW-1:0] rd_idx,
    input  logic [REGW-1:0] rt_idx,
    input  logic            reg_write,
    input  logic [1:0]      fwd_a_sel,
    input  logic [1:0]      fwd_b_sel,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_result,
    output logic            out_zero,
    output logic [XLEN-1:0] out_store_data,
    output logic [REGW-1:0] out_dest,
    output logic            out_reg_write,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MFHI = 4'b0011;
    localparam logic [3:0] OP_MFLO = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1101;
    localparam logic [3:0] OP_DIV  = 4'b1110;

    // Iteration state
    logic            r_busy;
    logic [CW-1:0]   r_count;
    logic            r_is_div;
    logic [XLEN-1:0] r_md_m;    // multiplicand (MULT) or divisor (DIV)
    logic [XLEN-1:0] r_w_hi;    // partial product high half / partial remainder
    logic [XLEN-1:0] r_w_lo;    // multiplier being shifted out / dividend shifting into quotient

    logic            w_accept;
    logic            w_is_md;
    logic [XLEN-1:0] w_a;
    logic [XLEN-1:0] w_b_fwd;
    logic [XLEN-1:0] w_b_op;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_sra;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic [XLEN:0]   w_div_diff;
    logic            w_div_ok;
    logic [XLEN-1:0] w_step_hi;
    logic [XLEN-1:0] w_step_lo;

    assign stall    = r_busy;
    assign w_accept = in_valid & ~r_busy;
    assign w_is_md  = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
    assign w_shamt  = imm[6+SHW-1:6];

    // Forwarding sits ahead of both the alu_src mux and the store-data path.
    always_comb begin
        w_a = rs_val;
        case (fwd_a_sel)
            2'b01:   w_a = out_result;
            2'b10:   w_a = wb_data;
            default: w_a = rs_val;
        endcase
        w_b_fwd = rt_val;
        case (fwd_b_sel)
            2'b01:   w_b_fwd = out_result;
            2'b10:   w_b_fwd = wb_data;
            default: w_b_fwd = rt_val;
        endcase
    end

    assign w_b_op = alu_src ? imm : w_b_fwd;
    assign w_sra  = $signed(w_b_op) >>> w_shamt;

    always_comb begin
        w_result = '0;
        case (alu_ctrl)
            OP_AND:  w_result = w_a & w_b_op;
            OP_OR:   w_result = w_a | w_b_op;
            OP_ADD:  w_result = w_a + w_b_op;
            OP_SUB:  w_result = w_a - w_b_op;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b_op))};
            OP_NOR:  w_result = ~(w_a | w_b_op);
            OP_SLL:  w_result = w_b_op << w_shamt;
            OP_SRL:  w_result = w_b_op >> w_shamt;
            OP_SRA:  w_result = w_sra;
            OP_MFHI: w_result = hi;
            OP_MFLO: w_result = lo;
            default: w_result = '0;
        endcase
    end

    // Shift-add multiply: add multiplicand when the multiplier LSB is set, then shift
    // the {sum, multiplier} pair right one bit; after XLEN steps {r_w_hi, r_w_lo} = A*B.
    assign w_mul_sum = {1'b0, r_w_hi} + (r_w_lo[0] ? {1'b0, r_md_m} : {(XLEN+1){1'b0}});

    // Restoring divide: shift the next dividend bit into the remainder, keep the
    // difference when it does not go negative. A zero divisor naturally yields
    // an all-ones quotient and the dividend as remainder.
    assign w_div_sh   = {r_w_hi, r_w_lo[XLEN-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_md_m};
    assign w_div_ok   = ~w_div_diff[XLEN];

    always_comb begin
        w_step_hi = w_mul_sum[XLEN:1];
        w_step_lo = {w_mul_sum[0], r_w_lo[XLEN-1:1]};
        if (r_is_div) begin
            w_step_hi = w_div_ok ? w_div_diff[XLEN-1:0] : w_div_sh[XLEN-1:0];
            w_step_lo = {r_w_lo[XLEN-2:0], w_div_ok};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_busy         <= 1'b0;
            r_count        <= '0;
            r_is_div       <= 1'b0;
            r_md_m         <= '0;
            r_w_hi         <= '0;
            r_w_lo         <= '0;
            hi             <= '0;
            lo             <= '0;
            out_valid      <= 1'b0;
            out_result     <= '0;
            out_zero       <= 1'b0;
            out_store_data <= '0;
            out_dest       <= '0;
            out_reg_write  <= 1'b0;
        end else begin
            if (r_busy) begin
                r_w_hi  <= w_step_hi;
                r_w_lo  <= w_step_lo;
                r_count <= r_count - CW'(1);
                // HI/LO only change on the final step so MFHI/MFLO never see partial values.
                if (r_count == CW'(1)) begin
                    r_busy <= 1'b0;
                    if (r_is_div) begin
                        hi <= w_step_hi;
                        lo <= w_step_lo;
                    end else begin
                        hi <= w_step_hi;
                        lo <= w_step_lo;
                    end
                end
            end

            if (w_accept && w_is_md) begin
                // MULT/DIV leaves a bubble in EX/MEM; alu_src is ignored.
                out_valid     <= 1'b0;
                out_reg_write <= 1'b0;
                r_busy        <= 1'b1;
                r_count       <= CW'(XLEN);
                r_is_div      <= (alu_ctrl == OP_DIV);
                r_w_hi        <= '0;
                if (alu_ctrl == OP_DIV) begin
                    r_md_m <= w_b_fwd;
                    r_w_lo <= w_a;
                end else begin
                    r_md_m <= w_a;
                    r_w_lo <= w_b_fwd;
                end
            end else if (w_accept) begin
                out_valid      <= 1'b1;
                out_result     <= w_result;
                out_zero       <= (w_result == '0);
                out_store_data <= w_b_fwd;
                out_dest       <= reg_dst ? rd_idx : rt_idx;
                out_reg_write  <= reg_write;
            end else begin
                out_valid     <= 1'b0;
                out_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_pipe.sv
module tb_execute_stage_pipe;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        in_valid;
    logic [31:0] rs_val, rt_val, imm, wb_data;
    logic        alu_src, reg_dst, reg_write;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_idx, rt_idx;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, out_valid, out_zero, out_reg_write;
    logic [31:0] out_result, out_store_data, hi, lo;
    logic [4:0]  out_dest;

    int total = 0;
    int bad   = 0;

    // Reference model state (expected EX/MEM and HI/LO contents)
    logic [31:0] m_res, m_store, m_hi, m_lo, m_phi, m_plo;
    logic [4:0]  m_dest;
    logic        m_zero, m_valid, m_rw, m_pend;

    execute_stage_pipe #(.XLEN(32), .REGW(5), .SHW(5)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .rs_val(rs_val), .rt_val(rt_val),
        .imm(imm), .alu_src(alu_src), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .rd_idx(rd_idx),
        .rt_idx(rt_idx), .reg_write(reg_write), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .wb_data(wb_data), .stall(stall), .out_valid(out_valid), .out_result(out_result),
        .out_zero(out_zero), .out_store_data(out_store_data), .out_dest(out_dest),
        .out_reg_write(out_reg_write), .hi(hi), .lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_res = 0; m_store = 0; m_hi = 0; m_lo = 0; m_dest = 0;
        m_zero = 0; m_valid = 0; m_rw = 0; m_pend = 0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                            input int sh);
        logic signed [31:0] sb;
        sb = b;
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd7:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            4'd8:  return b << sh;
            4'd9:  return b >> sh;
            4'd10: return sb >>> sh;
            4'd3:  return m_hi;
            4'd4:  return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s, input logic [31:0] r, input logic [31:0] wb);
        if (s == 2'b01) return m_res;
        if (s == 2'b10) return wb;
        return r;
    endfunction

    // Present one instruction for one edge (stall must be low) and update the model.
    task automatic issue(input logic [3:0] c, input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                         input logic [31:0] wb, input logic src, input logic [1:0] fa, input logic [1:0] fb,
                         input logic rdst, input logic [4:0] rd, input logic [4:0] rti, input logic rw);
        logic [31:0] a, bf, b;
        logic [63:0] p;
        alu_ctrl = c; rs_val = rs; rt_val = rt; imm = im; wb_data = wb; alu_src = src;
        fwd_a_sel = fa; fwd_b_sel = fb; reg_dst = rdst; rd_idx = rd; rt_idx = rti; reg_write = rw;
        in_valid = 1'b1;
        a  = pick(fa, rs, wb);
        bf = pick(fb, rt, wb);
        b  = src ? im : bf;
        if (c == 4'd13) begin
            p = {32'd0, a} * {32'd0, bf};
            m_phi = p[63:32]; m_plo = p[31:0];
            m_pend = 1; m_valid = 0; m_rw = 0;
        end else if (c == 4'd14) begin
            if (bf == 0) begin m_plo = 32'hFFFF_FFFF; m_phi = a; end
            else begin m_plo = a / bf; m_phi = a % bf; end
            m_pend = 1; m_valid = 0; m_rw = 0;
        end else begin
            m_res   = ref_alu(c, a, b, int'(im[10:6]));
            m_zero  = (m_res == 0);
            m_store = bf;
            m_dest  = rdst ? rd : rti;
            m_rw    = rw;
            m_valid = 1;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
        m_valid = 0; m_rw = 0;
    endtask

    // Run out a MULT/DIV; reports stalled cycles, cycles with out_valid high and HI/LO changes while stalled.
    task automatic wait_md(output int cyc, output int vcnt, output int chg);
        logic [31:0] h0, l0;
        h0 = hi; l0 = lo;
        cyc = 0; vcnt = 0; chg = 0;
        while (stall === 1'b1 && cyc < 200) begin
            if (out_valid !== 1'b0) vcnt++;
            if (hi !== h0 || lo !== l0) chg++;
            tick();
            cyc++;
        end
        if (m_pend) begin m_hi = m_phi; m_lo = m_plo; m_pend = 0; end
        m_valid = 0; m_rw = 0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        tick(); tick();
        total++;
        if ({out_valid, out_result, out_zero, out_store_data, out_dest, out_reg_write, hi, lo, stall} !== '0) begin
            bad++;
            $display("FAIL reset_state: got valid=%b res=%h hi=%h lo=%h stall=%b, want all zero",
                     out_valid, out_result, hi, lo, stall);
        end
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic test_add();
        issue(4'd2, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd3, 5'd9, 1'b1);
        total++;
        if (out_result !== 32'd12 || out_zero !== 1'b0) begin
            bad++; $display("FAIL add_result: got %0d zero=%b, want 12 zero=0", out_result, out_zero);
        end
        total++;
        if (out_dest !== 5'd3 || out_valid !== 1'b1 || out_reg_write !== 1'b1) begin
            bad++; $display("FAIL add_ctrl: got dest=%0d v=%b rw=%b, want 3 1 1", out_dest, out_valid, out_reg_write);
        end
        idle();
        total++;
        if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_result !== 32'd12 || out_dest !== 5'd3) begin
            bad++; $display("FAIL idle_hold: got v=%b rw=%b res=%0d dest=%0d, want 0 0 12 3",
                            out_valid, out_reg_write, out_result, out_dest);
        end
    endtask

    task automatic test_sub_slt();
        issue(4'd6, 32'd9, 32'd77, 32'd9, 32'd0, 1'b1, 2'b00, 2'b00, 1'b0, 5'd1, 5'd2, 1'b1);
        total++;
        if (out_result !== 32'd0 || out_zero !== 1'b1 || out_dest !== 5'd2 || out_store_data !== 32'd77) begin
            bad++; $display("FAIL sub_imm: got res=%0d zero=%b dest=%0d st=%0d, want 0 1 2 77",
                            out_result, out_zero, out_dest, out_store_data);
        end
        issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd4, 5'd2, 1'b1);
        total++;
        if (out_result !== 32'd1 || out_zero !== 1'b0) begin
            bad++; $display("FAIL slt_signed: got %0d zero=%b, want 1 zero=0", out_result, out_zero);
        end
    endtask

    task automatic test_fwd();
        issue(4'd2, 32'd10, 32'd10, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd5, 5'd0, 1'b1);
        issue(4'd2, 32'd111, 32'd222, 32'd0, 32'd30, 1'b0, 2'b01, 2'b10, 1'b1, 5'd6, 5'd0, 1'b1);
        total++;
        if (out_result !== 32'd50 || out_store_data !== 32'd30) begin
            bad++; $display("FAIL fwd: got res=%0d st=%0d, want 50 30", out_result, out_store_data);
        end
    endtask

    task automatic test_mult();
        int cyc, vcnt, chg;
        issue(4'd13, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'd0, 1'b1, 2'b00, 2'b00, 1'b1, 5'd7, 5'd0, 1'b1);
        total++;
        if (stall !== 1'b1 || out_valid !== 1'b0 || out_reg_write !== 1'b0) begin
            bad++; $display("FAIL mult_bubble: got stall=%b v=%b rw=%b, want 1 0 0", stall, out_valid, out_reg_write);
        end
        wait_md(cyc, vcnt, chg);
        total++;
        if (cyc !== 32 || vcnt !== 0 || chg !== 0) begin
            bad++; $display("FAIL mult_stall: got cycles=%0d valid_cycles=%0d hilo_changes=%0d, want 32 0 0",
                            cyc, vcnt, chg);
        end
        total++;
        if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL mult_hilo: got hi=%h lo=%h, want 00000001 fffffffe", hi, lo);
        end
        issue(4'd4, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd8, 5'd0, 1'b1);
        total++;
        if (out_result !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin
            bad++; $display("FAIL mflo_after: got %h v=%b, want fffffffe 1", out_result, out_valid);
        end
        issue(4'd3, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd8, 5'd0, 1'b1);
        total++;
        if (out_result !== 32'd1) begin
            bad++; $display("FAIL mfhi_after: got %h, want 00000001", out_result);
        end
    endtask

    task automatic test_div();
        int cyc, vcnt, chg;
        logic [31:0] keep;
        keep = m_res;
        issue(4'd14, 32'd17, 32'd5, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);
        // Junk presented during the stall must be ignored.
        in_valid = 1'b1; alu_ctrl = 4'd13; rs_val = 32'd1234; rt_val = 32'd99; fwd_a_sel = 2'b00; fwd_b_sel = 2'b00;
        wait_md(cyc, vcnt, chg);
        in_valid = 1'b0;
        total++;
        if (hi !== 32'd2 || lo !== 32'd3 || cyc !== 32 || vcnt !== 0 || out_result !== keep) begin
            bad++; $display("FAIL div_17_5: got hi=%0d lo=%0d cycles=%0d vcyc=%0d res=%h, want 2 3 32 0 %h",
                            hi, lo, cyc, vcnt, out_result, keep);
        end
        issue(4'd14, 32'd17, 32'd0, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);
        wait_md(cyc, vcnt, chg);
        total++;
        if (hi !== 32'd17 || lo !== 32'hFFFF_FFFF || cyc !== 32) begin
            bad++; $display("FAIL div_by_zero: got hi=%0d lo=%h cycles=%0d, want 17 ffffffff 32", hi, lo, cyc);
        end
    endtask

    task automatic test_reset_mid();
        issue(4'd13, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        total++;
        if (stall !== 1'b1) begin
            bad++; $display("FAIL mid_stall: got stall=%b, want 1", stall);
        end
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        model_reset();
        total++;
        if ({out_valid, out_result, out_zero, out_store_data, out_dest, out_reg_write, hi, lo, stall} !== '0) begin
            bad++; $display("FAIL reset_mid: got v=%b res=%h hi=%h lo=%h stall=%b, want all zero",
                            out_valid, out_result, hi, lo, stall);
        end
        issue(4'd2, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 2'b00, 2'b00, 1'b1, 5'd11, 5'd0, 1'b1);
        total++;
        if (out_result !== 32'd3 || out_valid !== 1'b1 || out_dest !== 5'd11 || hi !== 32'd0) begin
            bad++; $display("FAIL after_reset_add: got res=%0d v=%b dest=%0d hi=%h, want 3 1 11 0",
                            out_result, out_valid, out_dest, hi);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [16];
        logic [3:0] c;
        int cyc, vcnt, chg;
        ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd8, 4'd9, 4'd10, 4'd3, 4'd4, 4'd5, 4'd15, 4'd11, 4'd13, 4'd14};
        for (int n = 0; n < 60; n++) begin
            c = ops[$urandom_range(0, 13)];
            if ($urandom_range(0, 7) == 0) c = ops[$urandom_range(14, 15)];
            issue(c, $urandom, ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 1'($urandom_range(0, 1)));
            if (c == 4'd13 || c == 4'd14) begin
                wait_md(cyc, vcnt, chg);
                total++;
                if (hi !== m_hi || lo !== m_lo || cyc !== 32) begin
                    bad++; $display("FAIL rand_md op=%0d: got hi=%h lo=%h cycles=%0d, want %h %h 32",
                                    c, hi, lo, cyc, m_hi, m_lo);
                end
            end else begin
                total++;
                if (out_result !== m_res || out_zero !== m_zero) begin
                    bad++; $display("FAIL rand_alu op=%0d: got res=%h zero=%b, want %h %b",
                                    c, out_result, out_zero, m_res, m_zero);
                end
                total++;
                if (out_store_data !== m_store || out_dest !== m_dest || out_reg_write !== m_rw || out_valid !== 1'b1) begin
                    bad++; $display("FAIL rand_ctrl op=%0d: got st=%h dest=%0d rw=%b v=%b, want %h %0d %b 1",
                                    c, out_store_data, out_dest, out_reg_write, out_valid, m_store, m_dest, m_rw);
                end
            end
            if ($urandom_range(0, 4) == 0) begin
                idle();
                total++;
                if (out_valid !== 1'b0 || out_reg_write !== 1'b0 || out_result !== m_res) begin
                    bad++; $display("FAIL rand_idle: got v=%b rw=%b res=%h, want 0 0 %h",
                                    out_valid, out_reg_write, out_result, m_res);
                end
            end
        end
    endtask

    initial begin
        RST_N = 1'b0; in_valid = 0; rs_val = 0; rt_val = 0; imm = 0; wb_data = 0; alu_src = 0;
        alu_ctrl = 0; reg_dst = 0; rd_idx = 0; rt_idx = 0; reg_write = 0; fwd_a_sel = 0; fwd_b_sel = 0;
        model_reset();
        test_reset();
        test_add();
        test_sub_slt();
        test_fwd();
        test_mult();
        test_div();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
